// File: rtl/axil_adder_pkg.sv
// Shared constants and types for the AXI4-Lite multi-lane adder.
// Register offsets, response codes and channel FSM states.
package axil_adder_pkg;

  localparam int OFF_OPA     = 'h0;
  localparam int OFF_OPB     = 'h4;
  localparam int OFF_CTRL    = 'h8;
  localparam int OFF_RESULT  = 'hC;
  localparam int LANE_STRIDE = 'h10;
  localparam int ADDR_STATUS = 'h80;
  localparam int ADDR_INFO   = 'h84;

  localparam int CTRL_SUB_BIT = 0;
  localparam int CTRL_SAT_BIT = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_t;

endpackage

// File: rtl/axil_multi_adder_lane.sv
// One adder lane: registered add/sub with optional signed saturation.
// Ports: clk, rst_n, opa, opb, sub, sat in; result, carry, ovf out.
module adder_lane
  import axil_adder_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] opa,
  input  logic [DATA_WIDTH-1:0] opb,
  input  logic                  sub,
  input  logic                  sat,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry,
  output logic                  ovf
);

  localparam int DW = DATA_WIDTH;

  logic [DW-1:0] b_eff;
  logic [DW:0]   ext;
  logic [DW-1:0] raw;
  logic [DW-1:0] sat_val;
  logic [DW-1:0] nxt;
  logic          ovf_c;

  // Subtract is A + ~B + 1; overflow when the effective
  // operands agree in sign but the sum does not.
  always_comb begin
    b_eff   = sub ? ~opb : opb;
    ext     = {1'b0, opa} + {1'b0, b_eff}
            + {{DW{1'b0}}, sub};
    raw     = ext[DW-1:0];
    ovf_c   = (opa[DW-1] == b_eff[DW-1])
            && (raw[DW-1] != opa[DW-1]);
    sat_val = opa[DW-1] ? {1'b1, {(DW-1){1'b0}}}
                        : {1'b0, {(DW-1){1'b1}}};
    nxt     = (sat && ovf_c) ? sat_val : raw;
  end

  // For subtraction the carry flag reports borrow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      result <= nxt;
      carry  <= ext[DW] ^ sub;
      ovf    <= ovf_c;
    end
  end

endmodule

// File: rtl/axil_multi_adder.sv
// AXI4-Lite slave with NUM_CH adder lanes (OPA/OPB/CTRL/RESULT each),
// plus STATUS/INFO. Ports: s1_axi_* AW/W/B/AR/R channels, clk, aresetn.
module axil_multi_adder
  import axil_adder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_CH     = 4
) (
  input  logic                    s1_axi_aclk,
  input  logic                    s1_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
  input  logic                    s1_axi_awvalid,
  output logic                    s1_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
  input  logic                    s1_axi_wvalid,
  output logic                    s1_axi_wready,
  output logic [1:0]              s1_axi_bresp,
  output logic                    s1_axi_bvalid,
  input  logic                    s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
  input  logic                    s1_axi_arvalid,
  output logic                    s1_axi_arready,
  output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
  output logic [1:0]              s1_axi_rresp,
  output logic                    s1_axi_rvalid,
  input  logic                    s1_axi_rready
);

  localparam int SW = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] AMASK = ~ADDR_WIDTH'(3);
  localparam logic [15:0] INFO =
    {8'(DATA_WIDTH), 8'(NUM_CH)};

  function automatic logic [ADDR_WIDTH-1:0] reg_addr(
    input int n,
    input int off
  );
    return ADDR_WIDTH'(n * LANE_STRIDE + off);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] old,
    input logic [DATA_WIDTH-1:0] nw,
    input logic [SW-1:0]         s
  );
    logic [DATA_WIDTH-1:0] r;
    r = old;
    for (int i = 0; i < SW; i++)
      if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  wstate_t wstate, wstate_nxt;
  rstate_t rstate, rstate_nxt;

  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [SW-1:0]         w_strb_q;
  logic                  aw_hs, w_hs, ar_hs, commit;

  logic [ADDR_WIDTH-1:0] c_addr, ra;
  logic [DATA_WIDTH-1:0] c_data;
  logic [SW-1:0]         c_strb;
  logic [NUM_CH-1:0]     sel_opa, sel_opb, sel_ctrl;
  logic                  w_ok;

  logic [DATA_WIDTH-1:0] opa    [NUM_CH];
  logic [DATA_WIDTH-1:0] opb    [NUM_CH];
  logic [1:0]            ctrl   [NUM_CH];
  logic [DATA_WIDTH-1:0] result [NUM_CH];
  logic [NUM_CH-1:0]     carry, ovf;
  logic [2*NUM_CH-1:0]   status;

  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_ok;

  assign aw_hs = s1_axi_awvalid && s1_axi_awready;
  assign w_hs  = s1_axi_wvalid && s1_axi_wready;
  assign ar_hs = s1_axi_arvalid && s1_axi_arready;

  // Commit on the edge where both AW and W are held,
  // whether captured earlier or in this very cycle.
  assign commit = (wstate == W_IDLE)
                && (aw_held || aw_hs)
                && (w_held || w_hs);

  // ---------------- write FSM ----------------
  always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
    if (!s1_axi_aresetn) wstate <= W_IDLE;
    else                 wstate <= wstate_nxt;
  end

  always_comb begin
    wstate_nxt = wstate;
    unique case (wstate)
      W_IDLE: if (commit) wstate_nxt = W_RESP;
      W_RESP: if (s1_axi_bready) wstate_nxt = W_IDLE;
    endcase
  end

  // Readies are gated by reset so they drop the moment it asserts.
  always_comb begin
    s1_axi_awready = 1'b0;
    s1_axi_wready  = 1'b0;
    s1_axi_bvalid  = 1'b0;
    unique case (wstate)
      W_IDLE: begin
        s1_axi_awready = s1_axi_aresetn && !aw_held;
        s1_axi_wready  = s1_axi_aresetn && !w_held;
      end
      W_RESP: s1_axi_bvalid = 1'b1;
    endcase
  end

  always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
    if (!s1_axi_aresetn) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      s1_axi_bresp <= RESP_OKAY;
    end else if (commit) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      s1_axi_bresp <= w_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s1_axi_awaddr;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= s1_axi_wdata;
        w_strb_q <= s1_axi_wstrb;
      end
    end
  end

  // ---------------- write decode ----------------
  always_comb begin
    c_addr   = (aw_held ? aw_addr_q : s1_axi_awaddr) & AMASK;
    c_data   = w_held ? w_data_q : s1_axi_wdata;
    c_strb   = w_held ? w_strb_q : s1_axi_wstrb;
    sel_opa  = '0;
    sel_opb  = '0;
    sel_ctrl = '0;
    w_ok     = 1'b0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (c_addr == reg_addr(n, OFF_OPA)) begin
        sel_opa[n] = 1'b1;
        w_ok       = 1'b1;
      end
      if (c_addr == reg_addr(n, OFF_OPB)) begin
        sel_opb[n] = 1'b1;
        w_ok       = 1'b1;
      end
      if (c_addr == reg_addr(n, OFF_CTRL)) begin
        sel_ctrl[n] = 1'b1;
        w_ok        = 1'b1;
      end
    end
  end

  always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
    if (!s1_axi_aresetn) begin
      for (int n = 0; n < NUM_CH; n++) begin
        opa[n]  <= '0;
        opb[n]  <= '0;
        ctrl[n] <= '0;
      end
    end else if (commit) begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (sel_opa[n])
          opa[n] <= merge(opa[n], c_data, c_strb);
        if (sel_opb[n])
          opb[n] <= merge(opb[n], c_data, c_strb);
        if (sel_ctrl[n] && c_strb[0])
          ctrl[n] <= c_data[1:0];
      end
    end
  end

  // ---------------- lanes ----------------
  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    adder_lane #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_lane (
      .clk    (s1_axi_aclk),
      .rst_n  (s1_axi_aresetn),
      .opa    (opa[g]),
      .opb    (opb[g]),
      .sub    (ctrl[g][CTRL_SUB_BIT]),
      .sat    (ctrl[g][CTRL_SAT_BIT]),
      .result (result[g]),
      .carry  (carry[g]),
      .ovf    (ovf[g])
    );
  end

  always_comb begin
    status = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      status[2*n]   = carry[n];
      status[2*n+1] = ovf[n];
    end
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
    if (!s1_axi_aresetn) rstate <= R_IDLE;
    else                 rstate <= rstate_nxt;
  end

  always_comb begin
    rstate_nxt = rstate;
    unique case (rstate)
      R_IDLE: if (ar_hs) rstate_nxt = R_DATA;
      R_DATA: if (s1_axi_rready) rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    s1_axi_arready = 1'b0;
    s1_axi_rvalid  = 1'b0;
    unique case (rstate)
      R_IDLE: s1_axi_arready = s1_axi_aresetn;
      R_DATA: s1_axi_rvalid  = 1'b1;
    endcase
  end

  always_comb begin
    ra      = s1_axi_araddr & AMASK;
    rd_data = '0;
    rd_ok   = 1'b0;
    if (ra == ADDR_WIDTH'(ADDR_STATUS)) begin
      rd_data = DATA_WIDTH'(status);
      rd_ok   = 1'b1;
    end
    if (ra == ADDR_WIDTH'(ADDR_INFO)) begin
      rd_data = DATA_WIDTH'(INFO);
      rd_ok   = 1'b1;
    end
    for (int n = 0; n < NUM_CH; n++) begin
      if (ra == reg_addr(n, OFF_OPA)) begin
        rd_data = opa[n];
        rd_ok   = 1'b1;
      end
      if (ra == reg_addr(n, OFF_OPB)) begin
        rd_data = opb[n];
        rd_ok   = 1'b1;
      end
      if (ra == reg_addr(n, OFF_CTRL)) begin
        rd_data = DATA_WIDTH'(ctrl[n]);
        rd_ok   = 1'b1;
      end
      if (ra == reg_addr(n, OFF_RESULT)) begin
        rd_data = result[n];
        rd_ok   = 1'b1;
      end
    end
  end

  always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
    if (!s1_axi_aresetn) begin
      s1_axi_rdata <= '0;
      s1_axi_rresp <= RESP_OKAY;
    end else if (ar_hs) begin
      s1_axi_rdata <= rd_data;
      s1_axi_rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

endmodule

// File: tb/tb_axil_multi_adder.sv
// Scoreboard bench for axil_multi_adder (4 lanes, 32-bit).
// Reference model: plain signed/unsigned arithmetic on register shadows.
module tb_axil_multi_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [7:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;

  always #5 clk = ~clk;

  axil_multi_adder #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(8),
    .NUM_CH(4)
  ) dut (
    .s1_axi_aclk    (clk),
    .s1_axi_aresetn (rst_n),
    .s1_axi_awaddr  (awaddr),
    .s1_axi_awvalid (awvalid),
    .s1_axi_awready (awready),
    .s1_axi_wdata   (wdata),
    .s1_axi_wstrb   (wstrb),
    .s1_axi_wvalid  (wvalid),
    .s1_axi_wready  (wready),
    .s1_axi_bresp   (bresp),
    .s1_axi_bvalid  (bvalid),
    .s1_axi_bready  (bready),
    .s1_axi_araddr  (araddr),
    .s1_axi_arvalid (arvalid),
    .s1_axi_arready (arready),
    .s1_axi_rdata   (rdata),
    .s1_axi_rresp   (rresp),
    .s1_axi_rvalid  (rvalid),
    .s1_axi_rready  (rready)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [1:0]  bq [$];
  logic [33:0] rq [$];

  logic [31:0] m_opa  [4];
  logic [31:0] m_opb  [4];
  logic [1:0]  m_ctrl [4];

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void m_clear();
    for (int n = 0; n < 4; n++) begin
      m_opa[n] = '0; m_opb[n] = '0; m_ctrl[n] = '0;
    end
  endfunction

  // Lane behaviour from the arithmetic definition.
  function automatic void m_lane(input int n,
                                 output logic [31:0] res,
                                 output bit c, output bit v);
    int sa, sb;
    longint la, lb, r, ua, ub;
    sa = m_opa[n]; sb = m_opb[n];
    la = sa; lb = sb;
    ua = longint'(m_opa[n]) & 64'hFFFFFFFF;
    ub = longint'(m_opb[n]) & 64'hFFFFFFFF;
    if (m_ctrl[n][0]) begin
      r = la - lb;
      c = ua < ub;
    end else begin
      r = la + lb;
      c = (ua + ub) > 64'hFFFFFFFF;
    end
    v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    if (m_ctrl[n][1] && v)
      res = (r > 0) ? 32'h7FFFFFFF : 32'h80000000;
    else
      res = r[31:0];
  endfunction

  function automatic logic [33:0] exp_read(input logic [7:0] a);
    int al, n;
    logic [31:0] res, st;
    bit c, v;
    al = int'(a) & 'hFC;
    if (al < 'h40) begin
      n = al / 16;
      case (al % 16)
        0:       return {2'b00, m_opa[n]};
        4:       return {2'b00, m_opb[n]};
        8:       return {2'b00, 30'b0, m_ctrl[n]};
        default: begin
          m_lane(n, res, c, v);
          return {2'b00, res};
        end
      endcase
    end
    if (al == 'h80) begin
      st = '0;
      for (int k = 0; k < 4; k++) begin
        m_lane(k, res, c, v);
        st[2*k] = c; st[2*k+1] = v;
      end
      return {2'b00, st};
    end
    if (al == 'h84) return {2'b00, 32'h00002004};
    return {2'b10, 32'h0};
  endfunction

  function automatic void m_write(input logic [7:0] a,
                                  input logic [31:0] d,
                                  input logic [3:0] s);
    int al, n;
    al = int'(a) & 'hFC;
    n = al / 16;
    if (al < 'h40 && (al % 16) != 12) begin
      for (int i = 0; i < 4; i++) begin
        if (s[i] && al % 16 == 0) m_opa[n][8*i +: 8] = d[8*i +: 8];
        if (s[i] && al % 16 == 4) m_opb[n][8*i +: 8] = d[8*i +: 8];
      end
      if (al % 16 == 8 && s[0]) m_ctrl[n] = d[1:0];
      bq.push_back(2'b00);
    end else begin
      bq.push_back(2'b10);
    end
  endfunction

  // Monitor: compare every B and R handshake with the scoreboard.
  always @(negedge clk) begin
    logic [33:0] e;
    if (rst_n) begin
      if (bvalid && bready) begin
        if (bq.size() == 0) chk("b_unexpected", 32'(bresp), 32'hX);
        else chk("bresp", 32'(bresp), 32'(bq.pop_front()));
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) begin
          chk("r_unexpected", rdata, 32'hX);
        end else begin
          e = rq.pop_front();
          chk("rdata", rdata, e[31:0]);
          chk("rresp", 32'(rresp), 32'(e[33:32]));
        end
      end
    end
  end

  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
  task automatic wr(input logic [7:0] a, input logic [31:0] d,
                    input logic [3:0] s, input int lead,
                    input int hold);
    bit awd, wd, awh, wh;
    int cyc, al, wl;
    awd = 0; wd = 0; cyc = 0;
    al = lead > 0 ? lead : 0;
    wl = lead < 0 ? -lead : 0;
    m_write(a, d, s);
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = (al == 0);
    wvalid = (wl == 0);
    while (!(awd && wd)) begin
      @(negedge clk);
      awh = awvalid && awready;
      wh = wvalid && wready;
      @(posedge clk); #1;
      cyc++;
      if (awh) begin awd = 1; awvalid = 0; end
      if (wh) begin wd = 1; wvalid = 0; end
      if (!awd && cyc == al) awvalid = 1;
      if (!wd && cyc == wl) wvalid = 1;
      if (cyc > 40) begin
        chk("wr_handshake_timeout", 32'd0, 32'd1);
        awvalid = 0; wvalid = 0;
        return;
      end
    end
    repeat (hold) begin
      @(negedge clk);
      chk("b_hold_bvalid", 32'(bvalid), 32'd1);
      chk("b_hold_awready", 32'(awready), 32'd0);
      chk("b_hold_wready", 32'(wready), 32'd0);
    end
    if (hold > 0) begin @(posedge clk); #1; end
    bready = 1;
    cyc = 0;
    @(negedge clk);
    while (!bvalid) begin
      cyc++;
      if (cyc > 40) begin
        chk("b_timeout", 32'd0, 32'd1);
        bready = 0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic rd(input logic [7:0] a, input int hold);
    bit h;
    int cyc;
    cyc = 0;
    rq.push_back(exp_read(a));
    @(posedge clk); #1;
    araddr = a; arvalid = 1;
    forever begin
      @(negedge clk);
      h = arvalid && arready;
      @(posedge clk); #1;
      if (h) break;
      cyc++;
      if (cyc > 40) begin
        chk("ar_timeout", 32'd0, 32'd1);
        arvalid = 0;
        return;
      end
    end
    arvalid = 0;
    repeat (hold) begin
      @(negedge clk);
      chk("r_hold_rvalid", 32'(rvalid), 32'd1);
      chk("r_hold_arready", 32'(arready), 32'd0);
    end
    if (hold > 0) begin @(posedge clk); #1; end
    rready = 1;
    cyc = 0;
    @(negedge clk);
    while (!rvalid) begin
      cyc++;
      if (cyc > 40) begin
        chk("r_timeout", 32'd0, 32'd1);
        rready = 0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    rready = 0;
  endtask

  function automatic logic [31:0] rv();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'h7FFFFFFF;
      3:       return 32'h80000000;
      4:       return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [3:0] rs();
    if ($urandom_range(0, 3) == 0) return 4'($urandom_range(1, 15));
    return 4'hF;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_awready"}, 32'(awready), 32'd0);
    chk({tag, "_wready"}, 32'(wready), 32'd0);
    chk({tag, "_bvalid"}, 32'(bvalid), 32'd0);
    chk({tag, "_arready"}, 32'(arready), 32'd0);
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    chk({tag, "_bresp"}, 32'(bresp), 32'd0);
    chk({tag, "_rresp"}, 32'(rresp), 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cyc;
    bit h;
    m_clear();
    #12;
    chk_idle_outputs("reset");
    @(posedge clk); #1; rst_n = 1;
    @(negedge clk);
    chk("post_reset_awready", 32'(awready), 32'd1);
    chk("post_reset_wready", 32'(wready), 32'd1);
    chk("post_reset_arready", 32'(arready), 32'd1);

    // lane 0 add
    wr(8'h00, 32'd39, 4'hF, 0, 0);
    wr(8'h04, 32'd40, 4'hF, 0, 0);
    wr(8'h08, 32'd0, 4'hF, 0, 0);
    rd(8'h0C, 0);
    rd(8'h80, 0);
    // lane 1 subtract with borrow
    wr(8'h10, 32'd5, 4'hF, 0, 0);
    wr(8'h14, 32'd7, 4'hF, 0, 0);
    wr(8'h18, 32'd1, 4'hF, 0, 0);
    rd(8'h1C, 0);
    rd(8'h80, 0);
    // lane 2 saturate then wrap
    wr(8'h20, 32'h7FFFFFFF, 4'hF, 0, 0);
    wr(8'h24, 32'h1, 4'hF, 0, 0);
    wr(8'h28, 32'h2, 4'hF, 0, 0);
    rd(8'h2C, 0);
    rd(8'h80, 0);
    wr(8'h28, 32'h0, 4'hF, 0, 0);
    rd(8'h2C, 0);
    rd(8'h80, 0);
    // W before AW, strobed, with B back-pressure
    wr(8'h04, 32'h0, 4'hF, 0, 0);
    wr(8'h04, 32'hAABBCCDD, 4'h1, 3, 5);
    rd(8'h04, 2);
    // unmapped / alias / read-only
    rd(8'h90, 0);
    rd(8'h23, 0);
    wr(8'h0C, 32'd123, 4'hF, 0, 0);
    rd(8'h0C, 0);
    wr(8'h80, 32'hFFFFFFFF, 4'hF, -2, 0);
    rd(8'h84, 0);
    rd(8'h08, 0);

    for (int i = 0; i < 60; i++) begin
      n = $urandom_range(0, 3);
      wr(8'(n * 16), rv(), rs(),
         int'($urandom_range(0, 4)) - 2, $urandom_range(0, 2));
      wr(8'(n * 16 + 4), rv(), rs(),
         int'($urandom_range(0, 4)) - 2, $urandom_range(0, 2));
      wr(8'(n * 16 + 8), $urandom, 4'hF, 0, 0);
      rd(8'(n * 16 + 12), $urandom_range(0, 2));
      rd(8'h80, 0);
      if (i % 4 == 0) rd(8'($urandom_range(0, 255)), 0);
      if (i % 7 == 0)
        wr(8'($urandom_range(0, 255)), $urandom, rs(), 0, 0);
    end

    // reset while AW is captured and W is still pending
    @(posedge clk); #1;
    awaddr = 8'h00; wdata = 32'h12345678; wstrb = 4'hF;
    awvalid = 1;
    cyc = 0;
    forever begin
      @(negedge clk);
      h = awvalid && awready;
      @(posedge clk); #1;
      if (h || cyc > 40) break;
      cyc++;
    end
    awvalid = 0;
    @(negedge clk);
    chk("aw_held_awready", 32'(awready), 32'd0);
    chk("aw_held_wready", 32'(wready), 32'd1);
    #2 rst_n = 0;
    #1 chk_idle_outputs("mid_reset");
    m_clear();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    rd(8'h00, 0);
    rd(8'h14, 0);
    rd(8'h28, 0);
    rd(8'h2C, 0);
    rd(8'h80, 0);
    wr(8'h30, 32'd100, 4'hF, 0, 0);
    wr(8'h34, 32'd23, 4'hF, 1, 0);
    rd(8'h3C, 0);
    rd(8'h30, 0);

    repeat (4) @(posedge clk);
    chk("bq_empty", 32'(bq.size()), 32'd0);
    chk("rq_empty", 32'(rq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axil_multi_adder.md
Name: axil_multi_adder

Overview:
AXI4-Lite slave register block holding NUM_CH independent adder lanes, each with two operand registers, a control register and a registered result. Successor to the single-lane memory-mapped adder, adding per-lane add/subtract and signed saturation modes, carry/overflow status, byte strobes, proper 2-bit responses and full valid/ready back-pressure. Sits on the s1 AXI-Lite control bus as a peripheral.

Parameters:
DATA_WIDTH, 32, operand/result/bus data width (multiple of 8, 8..64)
ADDR_WIDTH, 8, byte address width (must cover 0x84)
NUM_CH, 4, number of adder lanes (1..8)

Ports:
s1_axi_aclk  in  1  clock
s1_axi_aresetn  in  1  reset, asynchronous assert, active-low
s1_axi_awaddr  in  ADDR_WIDTH  write address
s1_axi_awvalid  in  1  write address valid
s1_axi_awready  out  1  write address ready
s1_axi_wdata  in  DATA_WIDTH  write data
s1_axi_wstrb  in  DATA_WIDTH/8  byte strobes
s1_axi_wvalid  in  1  write data valid
s1_axi_wready  out  1  write data ready
s1_axi_bresp  out  2  write response (00 OKAY, 10 SLVERR)
s1_axi_bvalid  out  1  write response valid
s1_axi_bready  in  1  write response ready
s1_axi_araddr  in  ADDR_WIDTH  read address
s1_axi_arvalid  in  1  read address valid
s1_axi_arready  out  1  read address ready
s1_axi_rdata  out  DATA_WIDTH  read data
s1_axi_rresp  out  2  read response
s1_axi_rvalid  out  1  read data valid
s1_axi_rready  in  1  read data ready

Behaviour:
- Reset (aresetn=0, async): all ready/valid outputs 0, bresp/rresp 00, rdata 0, all OPA/OPB/CTRL/RESULT/flags 0. Aborts any in-flight transaction; nothing is committed.
- Map: lane n base = n*0x10: +0x0 OPA RW, +0x4 OPB RW, +0x8 CTRL RW (bit0 SUB, bit1 SAT, others read 0), +0xC RESULT RO. 0x80 STATUS RO: bit 2n = carry_n, bit 2n+1 = ovf_n. 0x84 INFO RO: [7:0]=NUM_CH, [15:8]=DATA_WIDTH. Low 2 address bits ignored. Anything else unmapped.
- Write FSM W_IDLE -> W_RESP: awready=1 while AW not yet captured and bvalid=0; wready likewise for W. AW and W captured independently, any order or same cycle. Commit edge T = edge on which both are held: mapped RW target gets byte-wise strobe merge; bvalid=1 from T+1, bresp=00. Unmapped or RO target: no state change, bresp=10. bvalid holds until bready; awready/wready stay 0 while bvalid=1. Next AW/W accepted the cycle after the B handshake.
- Read FSM R_IDLE -> R_DATA: arready=1 when rvalid=0. On AR handshake at edge T, rdata/rresp registered at T, rvalid=1 from T. rdata and rresp stable until rready. Unmapped: rdata=0, rresp=10. Read and write channels independent; a same-cycle read of a register being committed returns the pre-write value.
- Lane arithmetic, 1-cycle registered: RESULT/carry/ovf update at edge T+1 after any OPA/OPB/CTRL change at T. So a read issued after the B handshake always sees the new result.
  - SUB=0: sum = OPA+OPB, computed in DATA_WIDTH+1 bits; carry = bit DATA_WIDTH.
  - SUB=1: OPA + ~OPB + 1; carry = NOT carry-out, i.e. borrow, 1 when OPA<OPB unsigned.
  - ovf = signed overflow of the DATA_WIDTH result.
  - SAT=1 and ovf: RESULT = signed max (0x7FF..F) on positive overflow, signed min (0x800..0) on negative; ovf flag still 1. SAT=0 wraps.
- Flags are live (not sticky), and are only visible through STATUS.

Decomposition:
- Package axil_adder_pkg: offsets OFF_OPA/OFF_OPB/OFF_CTRL/OFF_RESULT, LANE_STRIDE=0x10, ADDR_STATUS=0x80, ADDR_INFO=0x84, CTRL_SUB_BIT=0, CTRL_SAT_BIT=1, RESP_OKAY=2'b00, RESP_SLVERR=2'b10, write/read state enums.
- Sub-module adder_lane: DATA_WIDTH parameter; inputs opa, opb, sub, sat; registered outputs result, carry, ovf. Top generates NUM_CH instances plus the AXI-Lite FSMs and decode.

Test Plan:
- Write 0x00=39, 0x04=40, CTRL=0; read 0x0C -> rdata 79, rresp 00; read 0x80 -> bits[1:0]=00.
- Lane 1: write 0x10=5, 0x14=7, 0x18=1; read 0x1C -> 0xFFFFFFFE; STATUS bit2 (borrow)=1, bit3=0.
- Lane 2: OPA=0x7FFFFFFF, OPB=1. CTRL=2 -> RESULT 0x7FFFFFFF, STATUS bit5=1. CTRL=0 -> RESULT 0x80000000, bit5=1.
- Send W three cycles before AW to 0x04 with wdata 0xAABBCCDD, wstrb=0x1 over prior 0 -> OPB=0x000000DD. Hold bready=0 for 5 cycles -> bvalid held, awready=wready=0 throughout.
- Read 0x90 and 0x23 (aliases 0x20, OK) -> SLVERR with rdata 0, then OKAY. Write 0x0C=123 -> bresp 10, RESULT unchanged. Read 0x84 -> 0x00002004.
- Deassert aresetn mid-write (AW captured, W pending) -> all outputs 0 immediately; registers 0; a fresh write after release completes normally.
